// File: rtl/display_pkg.sv
// Shared types and the hex-to-7-segment font used by the display scan controller.
package display_pkg;

    typedef logic [6:0] seg7_t;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] val;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, dp: 1'b0, val: 4'h0};

    // Segment order is {g,f,e,d,c,b,a}, so segment a sits in bit 0.
    function automatic seg7_t hex_to_seg7(input logic [3:0] val);
        seg7_t seg;
        case (val)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit decoder; a blanked digit drives no segments.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    output seg7_t      seg
);

    assign seg = blank ? 7'h00 : hex_to_seg7(val);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a small digit store.
// Optional build macro DISPLAY_DIM_EN adds a 4-bit brightness input that PWM-gates the digit enables.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int  N_DIGITS = 8,
    parameter int  SCAN_DIV = 1000,
    localparam int IDX_W    = $clog2(N_DIGITS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_pos,
    input  logic [3:0]          wr_dig,
    input  logic                wr_dp,
    input  logic                clear,
`ifdef DISPLAY_DIM_EN
    input  logic [3:0]          brightness,
`endif
    output logic                wr_err,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [IDX_W-1:0]    scan_idx
);

    localparam int PRESC_W = $clog2(SCAN_DIV);

    digit_t              r_entry [N_DIGITS];
    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [N_DIGITS-1:0] r_an;
    seg7_t               r_seg;
    logic                r_dp;
    logic                r_wr_err;

    logic                w_pos_ok;
    logic                w_presc_wrap;
    logic [PRESC_W-1:0]  w_presc_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_slot_live;
    digit_t              w_entry_sel;
    seg7_t               w_seg_dec;
    logic [N_DIGITS-1:0] w_an_onehot;
    logic                w_lit;

    // Range check by enumeration so non-power-of-two digit counts reject the unused codes.
    always_comb begin
        w_pos_ok = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (wr_pos == IDX_W'(i)) begin
                w_pos_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_entry[i] <= DIGIT_BLANK;
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (clear) begin
                    r_entry[i] <= DIGIT_BLANK;
                end else if (wr_en && (wr_pos == IDX_W'(i))) begin
                    r_entry[i] <= '{blank: 1'b0, dp: wr_dp, val: wr_dig};
                end
            end
        end
    end

    assign w_presc_wrap = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_presc_nxt  = w_presc_wrap ? '0 : r_presc + 1'b1;

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_presc_wrap) begin
            w_idx_nxt = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Outputs are built from the upcoming slot position so the ghost guard lines up with prescaler 0.
    assign w_slot_live  = (w_presc_nxt != '0);
    assign w_entry_sel  = r_entry[w_idx_nxt];
    assign w_an_onehot  = {{(N_DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt;

    seg7_decode u_decode (
        .val   (w_entry_sel.val),
        .blank (w_entry_sel.blank),
        .seg   (w_seg_dec)
    );

`ifdef DISPLAY_DIM_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_nxt;

    assign w_pwm_nxt = r_pwm + 4'd1;
    assign w_lit     = (w_pwm_nxt < brightness);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end
`else
    assign w_lit = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_an     <= '0;
            r_seg    <= '0;
            r_dp     <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_presc  <= w_presc_nxt;
            r_idx    <= w_idx_nxt;
            r_an     <= (w_slot_live && w_lit) ? w_an_onehot : '0;
            r_seg    <= w_slot_live ? w_seg_dec : '0;
            r_dp     <= w_slot_live && !w_entry_sel.blank && w_entry_sel.dp;
            r_wr_err <= wr_en && !clear && !w_pos_ok;
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = r_dp;
    assign wr_err   = r_wr_err;
    assign scan_idx = r_idx;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a slot-arithmetic reference model.
module tb_display_scan_ctrl;

    localparam int N_DIGITS = 6;
    localparam int SCAN_DIV = 5;
    localparam int IDX_W    = $clog2(N_DIGITS);

    logic                clock;
    logic                reset;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_pos;
    logic [3:0]          wr_dig;
    logic                wr_dp;
    logic                clear;
    logic                wr_err;
    logic [N_DIGITS-1:0] an;
    logic [6:0]          seg;
    logic                dp;
    logic [IDX_W-1:0]    scan_idx;
`ifdef DISPLAY_DIM_EN
    logic [3:0]          brightness;
`endif

    int checkCount;
    int passCount;

    // Reference model: time since reset release plus a plain digit table.
    int         t;
    bit         mBlank [N_DIGITS];
    bit         mDp    [N_DIGITS];
    logic [3:0] mVal   [N_DIGITS];
    logic [6:0] font   [16];

    logic [N_DIGITS-1:0] expAn;
    logic [6:0]          expSeg;
    logic                expDp;
    logic [IDX_W-1:0]    expIdx;
    logic                expErr;

    display_scan_ctrl #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_pos     (wr_pos),
        .wr_dig     (wr_dig),
        .wr_dp      (wr_dp),
        .clear      (clear),
`ifdef DISPLAY_DIM_EN
        .brightness (brightness),
`endif
        .wr_err     (wr_err),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .scan_idx   (scan_idx)
    );

    // 10 ns clock period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0d)", tag, observed, expected, t);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [IDX_W-1:0] pos, input logic [3:0] dig,
                                 input logic pnt, input logic clr);
        wr_en  = en;
        wr_pos = pos;
        wr_dig = dig;
        wr_dp  = pnt;
        clear  = clr;
    endtask

    task automatic modelReset();
        t = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            mBlank[i] = 1'b1;
            mDp[i]    = 1'b0;
            mVal[i]   = 4'h0;
        end
        expAn  = '0;
        expSeg = '0;
        expDp  = 1'b0;
        expIdx = '0;
        expErr = 1'b0;
    endtask

    // Expected outputs after an edge come from the slot position at that edge and the table before the edge.
    task automatic modelStep();
        int presc;
        int idx;
        bit lit;
        t++;
        presc = t % SCAN_DIV;
        idx   = (t / SCAN_DIV) % N_DIGITS;
        lit   = 1'b1;
`ifdef DISPLAY_DIM_EN
        lit = ((t % 16) < int'(brightness));
`endif
        expIdx = IDX_W'(idx);
        expAn  = (presc != 0 && lit) ? N_DIGITS'(1 << idx) : '0;
        expSeg = (presc != 0 && !mBlank[idx]) ? font[mVal[idx]] : 7'h00;
        expDp  = (presc != 0 && !mBlank[idx]) ? mDp[idx] : 1'b0;
        expErr = wr_en && !clear && (int'(wr_pos) >= N_DIGITS);
        if (clear) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                mBlank[i] = 1'b1;
            end
        end else if (wr_en && int'(wr_pos) < N_DIGITS) begin
            mBlank[wr_pos] = 1'b0;
            mDp[wr_pos]    = wr_dp;
            mVal[wr_pos]   = wr_dig;
        end
    endtask

    task automatic checkAll();
        checkOutput("scan_idx", 32'(scan_idx), 32'(expIdx));
        checkOutput("an",       32'(an),       32'(expAn));
        checkOutput("seg",      32'(seg),      32'(expSeg));
        checkOutput("dp",       32'(dp),       32'(expDp));
        checkOutput("wr_err",   32'(wr_err),   32'(expErr));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic stepCycle();
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 4'h0, 1'b0, 1'b0);
            stepCycle();
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef DISPLAY_DIM_EN
        brightness = 4'd15;
`endif
        applyStimulus(1'b0, '0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        modelReset();
        repeat (3) @(negedge clock);
        checkAll();
        reset = 1'b1;

        $display("[TB] blank display for two frames");
        idleCycles(2 * N_DIGITS * SCAN_DIV);

        $display("[TB] write digit 3 = 7 with point");
        applyStimulus(1'b1, IDX_W'(3), 4'h7, 1'b1, 1'b0);
        stepCycle();
        idleCycles(N_DIGITS * SCAN_DIV + 3);

        $display("[TB] out-of-range write");
        applyStimulus(1'b1, IDX_W'(N_DIGITS), 4'h5, 1'b1, 1'b0);
        stepCycle();
        idleCycles(N_DIGITS * SCAN_DIV);

        $display("[TB] write colliding with clear");
        applyStimulus(1'b1, IDX_W'(2), 4'hA, 1'b0, 1'b1);
        stepCycle();
        idleCycles(N_DIGITS * SCAN_DIV);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
`ifdef DISPLAY_DIM_EN
            if (i % 40 == 0) brightness = 4'($urandom_range(0, 15));
`endif
            applyStimulus(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, (1 << IDX_W) - 1)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0));
            stepCycle();
        end

        $display("[TB] asynchronous reset in slot 5");
        for (int i = 0; i < 2 * N_DIGITS * SCAN_DIV; i++) begin
            if (int'(expIdx) == 5 && (t % SCAN_DIV) == 2) break;
            applyStimulus(1'b1, IDX_W'($urandom_range(0, N_DIGITS - 1)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            stepCycle();
        end
        checkOutput("reached_slot5", 32'(expIdx), 32'd5);
        applyStimulus(1'b0, '0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clock);
        checkAll();
        reset = 1'b1;
        idleCycles(N_DIGITS * SCAN_DIV + 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
